// File: rtl/a2d_scan_seq.sv
// a2d_scan_seq: A2D scan sequencer that steps a channel list through a 16-bit SPI master,
// averaging 2^AVG_LOG2 conversions per result in single-shot or continuous mode.
module a2d_scan_seq #(
    parameter int          NUM_CH   = 3,
    parameter int          DATA_W   = 12,
    parameter logic [23:0] CH_MAP   = {15'd0, 3'd5, 3'd4, 3'd0},
    parameter int          AVG_LOG2 = 0,
    parameter logic [7:0]  RST_FILL = 8'b100
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     nxt,
    input  logic                     cont,
    output logic [NUM_CH*DATA_W-1:0] samples,
    output logic [NUM_CH-1:0]        smpl_vld,
    output logic [2:0]               cur_ch,
    output logic                     cnv_done,
    output logic                     busy,
    output logic                     SS_n,
    output logic                     SCLK,
    output logic                     MOSI,
    input  logic                     MISO
);
    localparam int AW = DATA_W + AVG_LOG2;
    localparam int CW = AVG_LOG2 + 1;
    localparam logic [CW-1:0] AVG_N = CW'(1) << AVG_LOG2;

    typedef enum logic [2:0] {IDLE, CMD, GAP, RD, UPD} state_t;

    state_t                    state_q, state_d;
    logic [2:0]                cur_ch_q, cur_ch_d;
    logic [CW-1:0]             avg_cnt_q, avg_cnt_d, avg_inc;
    logic [AW-1:0]             acc_q, acc_d;
    logic [NUM_CH*DATA_W-1:0]  samples_q, samples_d;
    logic [NUM_CH-1:0]         smpl_vld_q, smpl_vld_d;
    logic                      cnv_done_q, cnv_done_d;
    logic                      wrt;

    logic [1:0]                div_q, div_d;
    logic [3:0]                bit_q, bit_d;
    logic [15:0]               shft_q, shft_d;
    logic                      miso_q, miso_d, ss_n_q, ss_n_d, done_q, done_d;

    assign wrt     = (state_q == IDLE && (nxt | cont)) || state_q == GAP;
    assign avg_inc = avg_cnt_q + CW'(1);

    // SPI mode 0, SCLK = clk/4; MISO captured on the rising SCLK edge, shifted in on the falling one
    always_comb begin
        div_d  = div_q;
        bit_d  = bit_q;
        shft_d = shft_q;
        miso_d = miso_q;
        ss_n_d = ss_n_q;
        done_d = 1'b0;
        if (wrt) begin
            ss_n_d = 1'b0;
            div_d  = 2'd0;
            bit_d  = 4'd0;
            shft_d = {2'b00, CH_MAP[3*cur_ch_q +: 3], 11'h000};
        end else if (!ss_n_q) begin
            div_d  = div_q + 2'd1;
            miso_d = (div_q == 2'd1) ? MISO : miso_q;
            if (div_q == 2'd3) begin
                shft_d = {shft_q[14:0], miso_q};
                bit_d  = bit_q + 4'd1;
                ss_n_d = (bit_q == 4'hF);
                done_d = (bit_q == 4'hF);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cur_ch_d   = cur_ch_q;
        avg_cnt_d  = avg_cnt_q;
        acc_d      = acc_q;
        samples_d  = samples_q;
        smpl_vld_d = smpl_vld_q;
        cnv_done_d = 1'b0;
        case (state_q)
            IDLE: if (nxt | cont) begin
                state_d   = CMD;
                avg_cnt_d = '0;
                acc_d     = '0;
            end
            CMD: state_d = done_q ? GAP : CMD;
            GAP: state_d = RD;
            RD: if (done_q) begin
                acc_d     = acc_q + AW'(shft_q[DATA_W-1:0]);
                avg_cnt_d = avg_inc;
                state_d   = (avg_inc == AVG_N) ? UPD : GAP;
            end
            UPD: begin
                samples_d[cur_ch_q*DATA_W +: DATA_W] = DATA_W'(acc_q >> AVG_LOG2);
                smpl_vld_d = smpl_vld_q | (NUM_CH'(1) << cur_ch_q);
                cnv_done_d = 1'b1;
                cur_ch_d   = (cur_ch_q == 3'(NUM_CH - 1)) ? 3'd0 : cur_ch_q + 3'd1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cur_ch_q   <= 3'd0;
            avg_cnt_q  <= '0;
            acc_q      <= '0;
            smpl_vld_q <= '0;
            cnv_done_q <= 1'b0;
            for (int i = 0; i < NUM_CH; i++)
                samples_q[i*DATA_W +: DATA_W] <= {DATA_W{RST_FILL[i]}};
            div_q      <= 2'd0;
            bit_q      <= 4'd0;
            shft_q     <= 16'h0000;
            miso_q     <= 1'b0;
            ss_n_q     <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_ch_q   <= cur_ch_d;
            avg_cnt_q  <= avg_cnt_d;
            acc_q      <= acc_d;
            smpl_vld_q <= smpl_vld_d;
            cnv_done_q <= cnv_done_d;
            samples_q  <= samples_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            shft_q     <= shft_d;
            miso_q     <= miso_d;
            ss_n_q     <= ss_n_d;
            done_q     <= done_d;
        end
    end

    assign samples  = samples_q;
    assign smpl_vld = smpl_vld_q;
    assign cur_ch   = cur_ch_q;
    assign cnv_done = cnv_done_q;
    assign busy     = state_q != IDLE;
    assign SS_n     = ss_n_q;
    assign SCLK     = div_q[1];
    assign MOSI     = shft_q[15];
endmodule

// File: tb/tb_a2d_scan_seq.sv
// tb_a2d_scan_seq: two sequencer instances (defaults, and 1-channel 4x averaging) driven against
// a behavioural SPI A2D that returns the conversion of the previous command.
module tb_a2d_scan_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        nxt_a = 1'b0, cont_a = 1'b0, nxt_b = 1'b0, cont_b = 1'b0;
    logic [35:0] samples_a;
    logic [2:0]  vld_a, cur_a, cur_b;
    logic        done_a, busy_a, ss_n_a, sclk_a, mosi_a, miso_a;
    logic [11:0] samples_b;
    logic [0:0]  vld_b;
    logic        done_b, busy_b, ss_n_b, sclk_b, mosi_b, miso_b;

    a2d_scan_seq dut_a (
        .clk(clk), .rst(rst), .nxt(nxt_a), .cont(cont_a), .samples(samples_a), .smpl_vld(vld_a),
        .cur_ch(cur_a), .cnv_done(done_a), .busy(busy_a), .SS_n(ss_n_a), .SCLK(sclk_a),
        .MOSI(mosi_a), .MISO(miso_a)
    );

    a2d_scan_seq #(.NUM_CH(1), .AVG_LOG2(2), .RST_FILL(8'h00)) dut_b (
        .clk(clk), .rst(rst), .nxt(nxt_b), .cont(cont_b), .samples(samples_b), .smpl_vld(vld_b),
        .cur_ch(cur_b), .cnv_done(done_b), .busy(busy_b), .SS_n(ss_n_b), .SCLK(sclk_b),
        .MOSI(mosi_b), .MISO(miso_b)
    );

    // A2D model: conversions are taken from conv_* (random when empty) at the end of each command
    logic [15:0] sr_a = 16'h0, rx_a = 16'h0, pend_a = 16'h0;
    logic [15:0] sr_b = 16'h0, rx_b = 16'h0, pend_b = 16'h0;
    logic [15:0] conv_a[$], cmds_a[$], rsp_a[$];
    logic [15:0] conv_b[$], cmds_b[$], rsp_b[$];

    always @(negedge ss_n_a) begin sr_a = pend_a; rsp_a.push_back(pend_a); rx_a = 16'h0; end
    always @(posedge sclk_a) rx_a = {rx_a[14:0], mosi_a};
    always @(negedge sclk_a) if (!ss_n_a) sr_a = {sr_a[14:0], 1'b0};
    always @(posedge ss_n_a) begin
        cmds_a.push_back(rx_a);
        pend_a = (conv_a.size() > 0) ? conv_a.pop_front() : 16'($urandom);
    end
    assign miso_a = sr_a[15];

    always @(negedge ss_n_b) begin sr_b = pend_b; rsp_b.push_back(pend_b); rx_b = 16'h0; end
    always @(posedge sclk_b) rx_b = {rx_b[14:0], mosi_b};
    always @(negedge sclk_b) if (!ss_n_b) sr_b = {sr_b[14:0], 1'b0};
    always @(posedge ss_n_b) begin
        cmds_b.push_back(rx_b);
        pend_b = (conv_b.size() > 0) ? conv_b.pop_front() : 16'($urandom);
    end
    assign miso_b = sr_b[15];

    int n_chk = 0, n_err = 0, dcnt_a = 0, dcnt_b = 0;
    always @(negedge clk) begin
        if (done_a) dcnt_a++;
        if (done_b) dcnt_b++;
    end

    logic [2:0] cmap [3] = '{3'd0, 3'd4, 3'd5};

    function automatic logic [15:0] cmd_of(input int idx);
        return {2'b00, cmap[idx], 11'h000};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_done(input bit sel, input string nm);
        int c = 0;
        do begin @(negedge clk); c++; end while (!(sel ? done_b : done_a) && c < 2000);
        if (!(sel ? done_b : done_a)) begin
            n_chk++;
            n_err++;
            $display("FAIL %s: cnv_done low after %0d cycles, expected a pulse", nm, c);
        end
    endtask

    task automatic pulse_a();
        nxt_a = 1'b1; @(negedge clk); nxt_a = 1'b0;
    endtask

    task automatic pulse_b();
        nxt_b = 1'b1; @(negedge clk); nxt_b = 1'b0;
    endtask

    typedef struct {
        logic [15:0] conv;
        int          ch;
        logic [11:0] smp;
        logic [15:0] cmd;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at 1 ms, expected $finish");
        $fatal(1);
    end

    initial begin
        vec_t        tbl [6];
        logic [2:0]  vld_exp;
        logic [15:0] r;
        int          mi, base, n0, falls, s;
        logic        prev;
        tbl[0] = '{16'h0123, 0, 12'h123, 16'h0000};
        tbl[1] = '{16'h0456, 1, 12'h456, 16'h2000};
        tbl[2] = '{16'h0ABC, 2, 12'hABC, 16'h2800};
        tbl[3] = '{16'hF7FF, 0, 12'h7FF, 16'h0000};
        tbl[4] = '{16'h8000, 1, 12'h000, 16'h2000};
        tbl[5] = '{16'h1FFF, 2, 12'hFFF, 16'h2800};

        repeat (3) @(negedge clk);
        chk("rst_samples_a", samples_a, {12'hFFF, 12'h000, 12'h000});
        chk("rst_vld_a", vld_a, 0);
        chk("rst_busy_a", busy_a, 0);
        chk("rst_ssn_a", ss_n_a, 1);
        chk("rst_cur_a", cur_a, 0);
        chk("rst_done_a", done_a, 0);
        chk("rst_samples_b", samples_b, 0);
        chk("rst_ssn_b", ss_n_b, 1);
        rst = 1'b0;
        @(negedge clk);
        cmds_a.delete(); rsp_a.delete(); cmds_b.delete(); rsp_b.delete();

        vld_exp = 3'b000;
        for (int i = 0; i < 6; i++) begin
            conv_a.push_back(tbl[i].conv);
            conv_a.push_back(16'($urandom));
            n0 = cmds_a.size();
            pulse_a();
            chk("tbl_busy_rise", busy_a, 1);
            wait_done(0, "tbl_done");
            vld_exp = vld_exp | 3'(1 << tbl[i].ch);
            chk($sformatf("tbl%0d_sample", i), samples_a[tbl[i].ch*12 +: 12], tbl[i].smp);
            chk($sformatf("tbl%0d_vld", i), vld_a, vld_exp);
            chk($sformatf("tbl%0d_cur", i), cur_a, (tbl[i].ch + 1) % 3);
            chk($sformatf("tbl%0d_xfers", i), cmds_a.size() - n0, 2);
            chk($sformatf("tbl%0d_cmd0", i), cmds_a[n0], tbl[i].cmd);
            chk($sformatf("tbl%0d_cmd1", i), cmds_a[n0+1], tbl[i].cmd);
            @(negedge clk);
            chk("tbl_done_pulse", done_a, 0);
            chk("tbl_busy_fall", busy_a, 0);
        end

        mi = 0;
        cont_a = 1'b1;
        for (int k = 0; k < 7; k++) begin
            wait_done(0, "cont_done");
            r = rsp_a[$];
            chk($sformatf("cont%0d_sample", k), samples_a[mi*12 +: 12], r[11:0]);
            chk($sformatf("cont%0d_cmd_rd", k), cmds_a[$], cmd_of(mi));
            chk($sformatf("cont%0d_cmd", k), cmds_a[$-1], cmd_of(mi));
            mi = (mi + 1) % 3;
            chk($sformatf("cont%0d_cur", k), cur_a, mi);
            chk("cont_gap_idle", ss_n_a, 1);
            @(negedge clk);
            if (k < 6) chk("cont_gap_wrt", ss_n_a, 0);
            if (k == 5) cont_a = 1'b0;
        end
        n0 = cmds_a.size();
        repeat (100) @(negedge clk);
        chk("cont_stop_xfers", cmds_a.size() - n0, 0);
        chk("cont_stop_busy", busy_a, 0);

        base = dcnt_a;
        n0 = cmds_a.size();
        pulse_a();
        repeat (5) begin
            repeat ($urandom_range(5, 20)) @(negedge clk);
            chk("nxt_ign_busy", busy_a, 1);
            pulse_a();
        end
        repeat (300) @(negedge clk);
        chk("nxt_ign_results", dcnt_a - base, 1);
        chk("nxt_ign_xfers", cmds_a.size() - n0, 2);

        rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
        cont_a = 1'b1;
        wait_done(0, "rd_pre_done");
        falls = 0;
        prev = ss_n_a;
        for (int c = 0; c < 400 && falls < 2; c++) begin
            @(negedge clk);
            if (prev && !ss_n_a) falls++;
            prev = ss_n_a;
        end
        chk("reach_rd_ch1", falls, 2);
        repeat (20) @(negedge clk);
        chk("pre_rst_cur", cur_a, 1);
        chk("pre_rst_busy", busy_a, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_samples", samples_a, {12'hFFF, 12'h000, 12'h000});
        chk("mid_rst_vld", vld_a, 0);
        chk("mid_rst_busy", busy_a, 0);
        chk("mid_rst_ssn", ss_n_a, 1);
        chk("mid_rst_cur", cur_a, 0);
        chk("mid_rst_done", done_a, 0);
        @(negedge clk);
        rst = 1'b0;
        cont_a = 1'b0;
        n0 = cmds_a.size();
        repeat (200) @(negedge clk);
        chk("post_rst_xfers", cmds_a.size() - n0, 0);
        chk("post_rst_busy", busy_a, 0);
        pulse_a();
        wait_done(0, "post_rst_done");
        r = rsp_a[$];
        chk("post_rst_sample0", samples_a[11:0], r[11:0]);
        chk("post_rst_cmd", cmds_a[$], 16'h0000);
        chk("post_rst_cur", cur_a, 1);
        chk("post_rst_vld", vld_a, 3'b001);

        conv_b.push_back(16'd100);
        conv_b.push_back(16'd101);
        conv_b.push_back(16'd102);
        conv_b.push_back(16'd105);
        base = dcnt_b;
        n0 = cmds_b.size();
        pulse_b();
        wait_done(1, "avg_done");
        chk("avg_sample", samples_b, 12'h066);
        chk("avg_xfers", cmds_b.size() - n0, 5);
        for (int j = 0; j < 5; j++) chk($sformatf("avg_cmd%0d", j), cmds_b[n0+j], 16'h0000);
        chk("avg_cur", cur_b, 0);
        chk("avg_vld", vld_b, 1);
        repeat (50) @(negedge clk);
        chk("avg_one_result", dcnt_b - base, 1);

        for (int k = 0; k < 4; k++) begin
            pulse_b();
            wait_done(1, "avg_rand_done");
            s = 0;
            for (int j = 1; j <= 4; j++) begin
                r = rsp_b[rsp_b.size() - j];
                s += int'(r[11:0]);
            end
            chk($sformatf("avg_rand%0d_sample", k), samples_b, 12'(s / 4));
            chk($sformatf("avg_rand%0d_cur", k), cur_b, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
